// File: rtl/ram_arbiter_pkg.sv
// Shared types and helpers for the RAM arbiter slice.
package ram_arbiter_pkg;

    // Upper bound on requesters, sets the width of the one-hot helper input.
    localparam int MAX_REQ = 8;

    // Control pins of the shared RAM, both active low.
    typedef struct packed {
        logic cs_n;
        logic wr_n;
    } ram_ctrl_t;

    // Pin values while the RAM is not accessed.
    localparam ram_ctrl_t RAM_IDLE = '{cs_n: 1'b1, wr_n: 1'b1};

    // Index of the set bit in a one-hot vector; 0 for an all-zero vector.
    function automatic logic [2:0] onehot_to_index(input logic [MAX_REQ-1:0] onehot);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (onehot[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// priority pointer, pointer moves past the winner after each grant.
module rr_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0]      ptr_reg;
    logic [PW-1:0]      scan_idx;
    logic               found;
    logic [N_REQ-1:0]   gnt_next;
    logic [MAX_REQ-1:0] gnt_wide;
    logic [2:0]         win_idx;

    // Upward scan with wrap from the pointer; reset suppresses grants so a
    // request pending across reset is dropped.
    always_comb begin
        gnt_next = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = PW'((int'(ptr_reg) + k) % N_REQ);
            if (!found && req[scan_idx]) begin
                gnt_next[scan_idx] = 1'b1;
                found              = 1'b1;
            end
        end
        if (reset) begin
            gnt_next = '0;
        end
    end

    assign gnt = gnt_next;

    // Widen the grant to the helper's fixed width before index conversion.
    always_comb begin
        gnt_wide           = '0;
        gnt_wide[N_REQ-1:0] = gnt_next;
    end

    assign win_idx = onehot_to_index(gnt_wide);

    // Pointer moves to the slot after the winner; holds when nothing is granted.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_reg <= '0;
        end else if (|gnt_next) begin
            ptr_reg <= (win_idx == 3'(N_REQ - 1)) ? '0 : PW'(win_idx + 3'd1);
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAM read port and one RAM write port among N_REQ requesters with
// independent round-robin read and write arbitration.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DW    = 4,
    parameter int AW    = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    rd_req,
    input  logic [N_REQ*AW-1:0] rd_addr,
    output logic [N_REQ-1:0]    rd_gnt,
    output logic [N_REQ-1:0]    rd_valid,
    output logic [DW-1:0]       rd_data,
    input  logic [N_REQ-1:0]    wr_req,
    input  logic [N_REQ*AW-1:0] wr_addr,
    input  logic [N_REQ*DW-1:0] wr_data,
    output logic [N_REQ-1:0]    wr_gnt,
    output logic                ram_cs_n,
    output logic                ram_wr_n,
    output logic [AW-1:0]       ram_rd_addr,
    output logic [AW-1:0]       ram_wr_addr,
    output logic [DW-1:0]       ram_data_in,
    input  logic [DW-1:0]       ram_data_out
);

    logic [N_REQ-1:0] rd_valid_reg;
    logic [DW-1:0]    rd_data_reg;
    logic [AW-1:0]    rd_addr_sel [N_REQ];
    logic [AW-1:0]    wr_addr_sel [N_REQ];
    logic [DW-1:0]    wr_data_sel [N_REQ];
    ram_ctrl_t        ctrl;

    rr_arbiter #(.N_REQ(N_REQ)) u_rd_arb (
        .clk   (clk),
        .reset (reset),
        .req   (rd_req),
        .gnt   (rd_gnt)
    );

    rr_arbiter #(.N_REQ(N_REQ)) u_wr_arb (
        .clk   (clk),
        .reset (reset),
        .req   (wr_req),
        .gnt   (wr_gnt)
    );

    // Per-requester terms masked by the one-hot grant; OR-ing them gives the
    // winner's value, or zero when nobody is granted.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mux
            assign rd_addr_sel[gi] = {AW{rd_gnt[gi]}} & rd_addr[gi*AW +: AW];
            assign wr_addr_sel[gi] = {AW{wr_gnt[gi]}} & wr_addr[gi*AW +: AW];
            assign wr_data_sel[gi] = {DW{wr_gnt[gi]}} & wr_data[gi*DW +: DW];
        end
    endgenerate

    // AND-OR reduction of the masked terms into the RAM address/data pins.
    always_comb begin
        ram_rd_addr = '0;
        ram_wr_addr = '0;
        ram_data_in = '0;
        for (int i = 0; i < N_REQ; i++) begin
            ram_rd_addr = ram_rd_addr | rd_addr_sel[i];
            ram_wr_addr = ram_wr_addr | wr_addr_sel[i];
            ram_data_in = ram_data_in | wr_data_sel[i];
        end
    end

    // Chip select follows any grant, write enable follows the write grant.
    always_comb begin
        ctrl = RAM_IDLE;
        if ((|rd_gnt) || (|wr_gnt)) begin
            ctrl.cs_n = 1'b0;
        end
        if (|wr_gnt) begin
            ctrl.wr_n = 1'b0;
        end
    end

    assign ram_cs_n = ctrl.cs_n;
    assign ram_wr_n = ctrl.wr_n;

    // Capture the asynchronous RAM read for the granted reader; data hold
    // between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_reg <= '0;
            rd_data_reg  <= '0;
        end else begin
            rd_valid_reg <= rd_gnt;
            if (|rd_gnt) begin
                rd_data_reg <= ram_data_out;
            end
        end
    end

    assign rd_valid = rd_valid_reg;
    assign rd_data  = rd_data_reg;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: directed scenarios then randomized traffic,
// checked against a behavioural model of the arbitration and memory.
module tb_ram_arbiter;

    localparam int N  = 4;
    localparam int DW = 4;
    localparam int AW = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    rd_req, wr_req;
    logic [N*AW-1:0] rd_addr, wr_addr;
    logic [N*DW-1:0] wr_data;
    logic [N-1:0]    rd_gnt, wr_gnt, rd_valid;
    logic [DW-1:0]   rd_data;
    logic            ram_cs_n, ram_wr_n;
    logic [AW-1:0]   ram_rd_addr, ram_wr_addr;
    logic [DW-1:0]   ram_data_in, ram_data_out;

    ram_arbiter #(.N_REQ(N), .DW(DW), .AW(AW)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_gnt       (rd_gnt),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_gnt       (wr_gnt),
        .ram_cs_n     (ram_cs_n),
        .ram_wr_n     (ram_wr_n),
        .ram_rd_addr  (ram_rd_addr),
        .ram_wr_addr  (ram_wr_addr),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out)
    );

    always #5 clk = ~clk;

    // The physical RAM attached to the arbiter pins.
    logic [DW-1:0] ram_mem [1<<AW];
    assign ram_data_out = ram_mem[ram_rd_addr];
    always @(posedge clk) begin
        if (!ram_cs_n && !ram_wr_n) ram_mem[ram_wr_addr] <= ram_data_in;
    end

    // Reference model state.
    logic [DW-1:0] ref_mem [1<<AW];
    int rd_ptr_m, wr_ptr_m;
    logic prev_reset;
    logic [N-1:0] rd_hold, wr_hold;

    typedef struct {
        logic [N-1:0]  gnt;
        logic [DW-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Winner index by the round-robin rule, -1 when no request.
    function automatic int pick(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // Evaluate one cycle against the model (called mid-cycle, at negedge).
    task automatic model_check();
        int rw, ww;
        logic [N-1:0] erg, ewg;
        int era, ewa, ewd;
        rw = reset ? -1 : pick(rd_req, rd_ptr_m);
        ww = reset ? -1 : pick(wr_req, wr_ptr_m);
        erg = (rw < 0) ? '0 : N'(1 << rw);
        ewg = (ww < 0) ? '0 : N'(1 << ww);
        era = (rw < 0) ? 0 : int'(rd_addr[rw*AW +: AW]);
        ewa = (ww < 0) ? 0 : int'(wr_addr[ww*AW +: AW]);
        ewd = (ww < 0) ? 0 : int'(wr_data[ww*DW +: DW]);
        chk("rd_gnt", int'(rd_gnt), int'(erg));
        chk("wr_gnt", int'(wr_gnt), int'(ewg));
        chk("ram_cs_n", int'(ram_cs_n), (rw < 0 && ww < 0) ? 1 : 0);
        chk("ram_wr_n", int'(ram_wr_n), (ww < 0) ? 1 : 0);
        chk("ram_rd_addr", int'(ram_rd_addr), era);
        chk("ram_wr_addr", int'(ram_wr_addr), ewa);
        chk("ram_data_in", int'(ram_data_in), ewd);
        if (reset && prev_reset) begin
            chk("reset_rd_valid", int'(rd_valid), 0);
            chk("reset_rd_data", int'(rd_data), 0);
        end
        if (reset) begin
            rd_ptr_m = 0;
            wr_ptr_m = 0;
            rd_hold  = '0;
            wr_hold  = '0;
        end else begin
            if (rw >= 0) begin
                exp_q.push_back('{gnt: erg, data: ref_mem[era]});
                rd_ptr_m = (rw + 1) % N;
            end
            if (ww >= 0) begin
                ref_mem[ewa] = DW'(ewd);
                wr_ptr_m = (ww + 1) % N;
            end
            rd_hold = rd_req & ~erg;
            wr_hold = wr_req & ~ewg;
        end
        prev_reset = reset;
    endtask

    task automatic step();
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every returned read is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rd_valid != '0) begin
            if (exp_q.size() == 0) begin
                chk("rd_valid_spurious", int'(rd_valid), 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rd_valid", int'(rd_valid), int'(e.gnt));
                chk("rd_data", int'(rd_data), int'(e.data));
            end
        end
    end

    task automatic idle();
        rd_req = '0;
        wr_req = '0;
    endtask

    // Pending requests keep address/data; free requesters may start a new one.
    task automatic drive_random();
        for (int i = 0; i < N; i++) begin
            if (!rd_hold[i]) begin
                rd_req[i] = ($urandom_range(0, 2) != 0);
                rd_addr[i*AW +: AW] = AW'($urandom);
            end
            if (!wr_hold[i]) begin
                wr_req[i] = ($urandom_range(0, 2) != 0);
                wr_addr[i*AW +: AW] = AW'($urandom);
                wr_data[i*DW +: DW] = DW'($urandom);
            end
        end
        reset = ($urandom_range(0, 49) == 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram_mem[i] = '0;
            ref_mem[i] = '0;
        end
        rd_ptr_m = 0; wr_ptr_m = 0;
        prev_reset = 1'b0;
        rd_hold = '0; wr_hold = '0;
        rd_addr = '0; wr_addr = '0; wr_data = '0;

        // Reset with all requests high.
        reset = 1'b1; rd_req = '1; wr_req = '1;
        step(); step();
        $display("txn reset: grants held off for 2 cycles");

        // Single write by requester 2, then read back by requester 1.
        reset = 1'b0; idle();
        wr_req = 4'b0100; wr_addr[2*AW +: AW] = 3'd5; wr_data[2*DW +: DW] = 4'hA;
        step();
        idle(); rd_req = 4'b0010; rd_addr[1*AW +: AW] = 3'd5;
        step();
        idle(); step();
        $display("txn write/read: req2 wrote addr5, req1 read addr5");

        // Fairness from a fresh pointer.
        reset = 1'b1; step();
        reset = 1'b0; wr_req = '1;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N; i++) begin
                wr_addr[i*AW +: AW] = AW'($urandom);
                wr_data[i*DW +: DW] = DW'($urandom);
            end
            step();
        end
        idle();
        $display("txn fairness: 8 cycles of 4 competing writers");

        // Pointer skip and wrap: move rd_ptr to 3, then readers 0 and 1.
        rd_req = 4'b0100; step();
        rd_req = 4'b0011; step();
        rd_req = 4'b0010; step();
        rd_req = 4'b1111; step();
        idle(); step();
        $display("txn skip/wrap: rd_ptr 3 with requests 0011");

        // Same-address read and write in one cycle returns old data.
        wr_req = 4'b0001; wr_addr[0 +: AW] = 3'd3; wr_data[0 +: DW] = 4'h1;
        step();
        wr_data[0 +: DW] = 4'h7;
        rd_req = 4'b0010; rd_addr[1*AW +: AW] = 3'd3;
        step();
        wr_req = '0; step();
        idle(); step();
        $display("txn same-address: old data then new data");

        // Reset while three readers are pending.
        rd_req = 4'b0111;
        rd_addr[0 +: AW] = 3'd1; rd_addr[1*AW +: AW] = 3'd2; rd_addr[2*AW +: AW] = 3'd3;
        step();
        reset = 1'b1; step();
        reset = 1'b0; rd_req = 4'b0110; step();
        idle(); step();
        $display("txn reset mid-stream: readers dropped, lowest index wins after");

        // Randomized traffic honouring the hold-until-granted protocol.
        for (int c = 0; c < 400; c++) begin
            drive_random();
            step();
            $display("txn rand %0d: rst=%0b rd_req=%b wr_req=%b rd_gnt=%b wr_gnt=%b",
                     c, reset, rd_req, wr_req, rd_gnt, wr_gnt);
        end
        reset = 1'b0; idle();
        step(); step(); step();

        chk("pending_reads", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
